// File: rtl/fhg_pkg.sv
// Shared types for the DCMAC RX segment repacker: segment geometry, FIFO entry
// layout and the input-side packet state.
package fhg_pkg;

  localparam int SEG_W     = 128;
  localparam int SEG_IN    = 12;
  localparam int SEG_OUT   = 8;
  localparam int MTY_W     = 4;
  localparam int SEG_BYTES = SEG_W / 8;

  typedef struct packed {
    logic [SEG_W-1:0] dat;
    logic             eop;
    logic             err;
    logic [MTY_W-1:0] mty;
    logic             abort;
  } seg_entry_t;

  localparam int ENTRY_W = $bits(seg_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INPKT   = 2'd1,
    ST_ABORT   = 2'd2,
    ST_DISCARD = 2'd3
  } in_state_t;

  // Byte enables of an end-of-packet segment: empty bytes sit at the top.
  function automatic logic [SEG_BYTES-1:0] eop_keep(input logic [MTY_W-1:0] mty);
    eop_keep = '0;
    for (int b = 0; b < SEG_BYTES; b++)
      if (b < SEG_BYTES - int'(mty)) eop_keep[b] = 1'b1;
  endfunction

endpackage

// File: rtl/seg_fifo_mw.sv
// Segment FIFO: writes 0-12 compacted entries and retires 0-8 entries per cycle,
// exposing the occupancy and the first eight head entries combinationally.
module seg_fifo_mw
  import fhg_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    wr_cnt_i,
  input  logic [SEG_IN*ENTRY_W-1:0]     wr_data_i,
  input  logic [3:0]                    rd_cnt_i,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic [SEG_OUT*ENTRY_W-1:0]    head_o
);

  localparam int AW = $clog2(DEPTH);

  seg_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(wr_cnt_i);
      rd_ptr_q <= rd_ptr_q + AW'(rd_cnt_i);
      count_q  <= count_q + (AW+1)'(wr_cnt_i) - (AW+1)'(rd_cnt_i);
    end
  end

  // Storage is data only; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SEG_IN; i++)
      if (4'(i) < wr_cnt_i)
        mem_q[wr_ptr_q + AW'(i)] <= wr_data_i[i*ENTRY_W +: ENTRY_W];
  end

  always_comb begin
    head_o = '0;
    for (int k = 0; k < SEG_OUT; k++)
      head_o[k*ENTRY_W +: ENTRY_W] = mem_q[rd_ptr_q + AW'(k)];
  end

  assign count_o = count_q;

endmodule

// File: rtl/dcmac_rx_axis_packer.sv
// Repacks the 12-segment DCMAC RX bus into 8-segment CASPER AXI-Stream beats,
// dropping whole cycles on FIFO overflow and closing truncated packets with an abort.
module dcmac_rx_axis_packer
  import fhg_pkg::*;
#(
  parameter int CHANNEL_ID = 0,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          dcmac_rx_id,
  input  logic [11:0]         dcmac_rx_ena,
  input  logic [11:0]         dcmac_rx_sop,
  input  logic [11:0]         dcmac_rx_eop,
  input  logic [11:0]         dcmac_rx_err,
  input  logic [47:0]         dcmac_rx_mty,
  input  logic [1535:0]       dcmac_rx_dat,
  input  logic [335:0]        dcmac_rx_preamble,
  input  logic [5:0]          dcmac_rx_vld,
  output logic [1023:0]       casper_rx_tdata,
  output logic [127:0]        casper_rx_tkeep,
  output logic                casper_rx_tvalid,
  input  logic                casper_rx_tready,
  output logic                casper_rx_tlast,
  output logic                casper_rx_tuser,
  output logic [CNT_W-1:0]    rx_pkt_cnt,
  output logic [CNT_W-1:0]    rx_drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  in_state_t                  state_q, state_d, walk_state;
  logic [SEG_IN-1:0]          seg_vld, seg_take;
  logic [3:0]                 n_vld, wr_cnt, rd_cnt;
  logic [CW-1:0]              fifo_count, free_w;
  logic                       accept, overflow;
  seg_entry_t                 wr_ent [SEG_IN];
  logic [SEG_IN*ENTRY_W-1:0]  wr_flat;
  logic [SEG_OUT*ENTRY_W-1:0] head_flat;
  seg_entry_t                 hd [SEG_OUT];

  logic [1023:0]              beat_data;
  logic [127:0]               beat_keep;
  logic [3:0]                 beat_len;
  logic [2:0]                 last_idx;
  logic                       beat_last, beat_user, beat_ok, load;

  logic [1023:0]              tdata_q;
  logic [127:0]               tkeep_q;
  logic                       tvalid_q, tlast_q, tuser_q;
  logic [CNT_W-1:0]           pkt_cnt_q, drop_cnt_q;
  logic                       unused_preamble;

  assign unused_preamble = ^dcmac_rx_preamble;

  always_comb begin
    n_vld = '0;
    for (int i = 0; i < SEG_IN; i++) begin
      seg_vld[i] = dcmac_rx_vld[i/2] && dcmac_rx_ena[i] && (dcmac_rx_id == 3'(CHANNEL_ID));
      n_vld      = n_vld + 4'(seg_vld[i]);
    end
  end

  // Free space is taken before this cycle's pop so acceptance never depends on tready.
  assign free_w   = CW'(FIFO_DEPTH) - fifo_count;
  assign accept   = CW'(n_vld) <= free_w;
  assign overflow = (n_vld != 4'd0) && !accept;

  // Walk the segments in index order; several sop/eop pairs may share a cycle.
  always_comb begin
    walk_state = state_q;
    seg_take   = '0;
    for (int i = 0; i < SEG_IN; i++) begin
      if (seg_vld[i]) begin
        if (dcmac_rx_sop[i]) walk_state = ST_INPKT;
        if (walk_state == ST_INPKT) begin
          seg_take[i] = 1'b1;
          if (dcmac_rx_eop[i]) walk_state = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ABORT: if (free_w != '0) state_d = ST_DISCARD;
      default: begin
        if (overflow) state_d = (state_q == ST_INPKT) ? ST_ABORT : state_q;
        else          state_d = walk_state;
      end
    endcase
  end

  // Push side: either the single abort marker or the compacted accepted segments.
  always_comb begin
    wr_cnt = '0;
    for (int i = 0; i < SEG_IN; i++) wr_ent[i] = '0;
    if (state_q == ST_ABORT) begin
      if (free_w != '0) begin
        wr_ent[0].eop   = 1'b1;
        wr_ent[0].err   = 1'b1;
        wr_ent[0].abort = 1'b1;
        wr_cnt          = 4'd1;
      end
    end else if (!overflow) begin
      for (int i = 0; i < SEG_IN; i++) begin
        if (seg_take[i]) begin
          wr_ent[wr_cnt].dat = dcmac_rx_dat[i*SEG_W +: SEG_W];
          wr_ent[wr_cnt].eop = dcmac_rx_eop[i];
          wr_ent[wr_cnt].err = dcmac_rx_err[i] & dcmac_rx_eop[i];
          wr_ent[wr_cnt].mty = dcmac_rx_eop[i] ? dcmac_rx_mty[i*MTY_W +: MTY_W] : '0;
          wr_cnt             = wr_cnt + 4'd1;
        end
      end
    end
  end

  always_comb begin
    wr_flat = '0;
    for (int i = 0; i < SEG_IN; i++) wr_flat[i*ENTRY_W +: ENTRY_W] = wr_ent[i];
  end

  seg_fifo_mw #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_cnt_i  (wr_cnt),
    .wr_data_i (wr_flat),
    .rd_cnt_i  (rd_cnt),
    .count_o   (fifo_count),
    .head_o    (head_flat)
  );

  // Beat formation from the FIFO head: cut at the first eop/abort, else take eight.
  always_comb begin
    beat_len  = 4'd8;
    last_idx  = 3'd7;
    beat_last = 1'b0;
    beat_data = '0;
    beat_keep = '0;
    for (int k = 0; k < SEG_OUT; k++) begin
      hd[k] = head_flat[k*ENTRY_W +: ENTRY_W];
      if (!beat_last && (CW'(k) < fifo_count) && (hd[k].eop || hd[k].abort)) begin
        beat_last = 1'b1;
        beat_len  = 4'(k + 1);
        last_idx  = 3'(k);
      end
    end
    for (int k = 0; k < SEG_OUT; k++) begin
      if ((4'(k) < beat_len) && !hd[k].abort) begin
        beat_data[k*SEG_W +: SEG_W]         = hd[k].dat;
        beat_keep[k*SEG_BYTES +: SEG_BYTES] = hd[k].eop ? eop_keep(hd[k].mty) : '1;
      end
    end
    beat_user = hd[last_idx].err | hd[last_idx].abort;
    beat_ok   = beat_last || (fifo_count >= CW'(SEG_OUT));
  end

  assign load   = beat_ok && (!tvalid_q || casper_rx_tready);
  assign rd_cnt = load ? beat_len : 4'd0;

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else if (load) begin
      tvalid_q <= 1'b1;
      tdata_q  <= beat_data;
      tkeep_q  <= beat_keep;
      tlast_q  <= beat_last;
      tuser_q  <= beat_user;
    end else if (casper_rx_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (tvalid_q && casper_rx_tready && tlast_q) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
      if (overflow) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign casper_rx_tdata  = tdata_q;
  assign casper_rx_tkeep  = tkeep_q;
  assign casper_rx_tvalid = tvalid_q;
  assign casper_rx_tlast  = tlast_q;
  assign casper_rx_tuser  = tuser_q;
  assign rx_pkt_cnt       = pkt_cnt_q;
  assign rx_drop_cnt      = drop_cnt_q;

endmodule
